// File: rtl/pingpong_pkg.sv
// Shared constants for the two-bank line buffer controller and its sender.
package pingpong_pkg;

  localparam int unsigned PP_DATA_W = 24;
  localparam int unsigned PP_DEPTH  = 80;
  localparam int unsigned PP_ADDR_W = 7;
  localparam int unsigned FRAME_W   = 24;

  typedef logic [1:0] bank_state_t;

  localparam bank_state_t BANK_EMPTY   = 2'd0;
  localparam bank_state_t BANK_FILLING = 2'd1;
  localparam bank_state_t BANK_FULL    = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pingpong_if.sv
// Source-write and sender-read handshake between the line buffer and its neighbours.
interface pingpong_if import pingpong_pkg::*; #(
  parameter int unsigned DATA_W = PP_DATA_W
) ();

  logic [DATA_W-1:0] wr_data_in;
  logic              wr_valid_in;
  logic              wr_ready_out;
  logic              read_pingpong_in;
  logic [DATA_W-1:0] pingpong_data_out;
  logic              pingpong_data_valid_out;
  logic              pingpong_ready_out;

  modport master (
    output wr_data_in, wr_valid_in, read_pingpong_in,
    input  wr_ready_out, pingpong_data_out, pingpong_data_valid_out, pingpong_ready_out
  );

  modport slave (
    input  wr_data_in, wr_valid_in, read_pingpong_in,
    output wr_ready_out, pingpong_data_out, pingpong_data_valid_out, pingpong_ready_out
  );

endinterface

// File: rtl/pingpong_bank_ram.sv
// Simple dual-port RAM holding both banks; {sel, addr} maps to sel*DEPTH + addr.
module pingpong_bank_ram import pingpong_pkg::*; #(
  parameter int unsigned DATA_W = PP_DATA_W,
  parameter int unsigned DEPTH  = PP_DEPTH,
  parameter int unsigned ADDR_W = PP_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned PA_W = $clog2(2 * DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [PA_W-1:0] phys(input logic [ADDR_W:0] a);
    return a[ADDR_W] ? PA_W'(DEPTH) + PA_W'(a[ADDR_W-1:0]) : PA_W'(a[ADDR_W-1:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[phys(waddr)] <= wdata;
    if (re) rdata_q <= mem[phys(raddr)];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_ctrl.sv
// Two-bank line buffer controller: fills banks from the source stream and
// serves word reads to the pixel sender, with frame-done and underrun reporting.
module pingpong_ctrl import pingpong_pkg::*; #(
  parameter int unsigned DATA_W = PP_DATA_W,
  parameter int unsigned DEPTH  = PP_DEPTH,
  parameter int unsigned ADDR_W = PP_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [FRAME_W-1:0] frame_words_in,
  pingpong_if.slave          pp,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               underrun_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [0:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_words_q, frame_words_d;
  logic [FRAME_W-1:0] wr_total_q, wr_total_d;
  logic [FRAME_W-1:0] rd_total_q, rd_total_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  bank_state_t        bank_q [2];
  bank_state_t        bank_d [2];
  logic [CNT_W-1:0]   cnt_q [2];
  logic [CNT_W-1:0]   cnt_d [2];
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               underrun_q, underrun_d;

  logic               run_c, wr_ready_c, wr_fire_c, wr_close_c;
  logic               rd_full_c, rd_fire_c, rd_last_c;
  logic [FRAME_W-1:0] rd_total_next_c;
  logic [DATA_W-1:0]  ram_rdata;

  assign run_c           = (state_q == ST_RUN);
  assign wr_ready_c      = run_c && (bank_q[wr_sel_q] != BANK_FULL) && (wr_total_q < frame_words_q);
  assign wr_fire_c       = wr_ready_c && pp.wr_valid_in;
  assign wr_close_c      = (wr_addr_q == ADDR_W'(DEPTH - 1)) ||
                           (wr_total_q == frame_words_q - FRAME_W'(1));
  assign rd_full_c       = (bank_q[rd_sel_q] == BANK_FULL);
  assign rd_fire_c       = run_c && pp.read_pingpong_in && rd_full_c;
  assign rd_last_c       = (CNT_W'(rd_addr_q) == cnt_q[rd_sel_q] - CNT_W'(1));
  assign rd_total_next_c = rd_total_q + FRAME_W'(cnt_q[rd_sel_q]);

  // Next-state: frame sequencing, bank fill/drain bookkeeping and status flags
  always_comb begin
    state_d       = state_q;
    frame_words_d = frame_words_q;
    wr_total_d    = wr_total_q;
    rd_total_d    = rd_total_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    bank_d[0]     = bank_q[0];
    bank_d[1]     = bank_q[1];
    cnt_d[0]      = cnt_q[0];
    cnt_d[1]      = cnt_q[1];
    valid_d       = rd_fire_c;
    done_d        = 1'b0;
    underrun_d    = underrun_q;

    if (state_q == ST_IDLE) begin
      if (start_in && (frame_words_in != '0)) begin
        state_d       = ST_RUN;
        frame_words_d = frame_words_in;
        wr_total_d    = '0;
        rd_total_d    = '0;
        wr_sel_d      = 1'b0;
        rd_sel_d      = 1'b0;
        wr_addr_d     = '0;
        rd_addr_d     = '0;
        bank_d[0]     = BANK_EMPTY;
        bank_d[1]     = BANK_EMPTY;
        cnt_d[0]      = '0;
        cnt_d[1]      = '0;
        underrun_d    = 1'b0;
      end
    end else begin
      if (wr_fire_c) begin
        wr_total_d = wr_total_q + FRAME_W'(1);
        if (wr_close_c) begin
          bank_d[wr_sel_q] = BANK_FULL;
          cnt_d[wr_sel_q]  = CNT_W'(wr_addr_q) + CNT_W'(1);
          wr_addr_d        = '0;
          wr_sel_d         = ~wr_sel_q;
        end else begin
          bank_d[wr_sel_q] = BANK_FILLING;
          wr_addr_d        = wr_addr_q + ADDR_W'(1);
        end
      end
      if (pp.read_pingpong_in && !rd_full_c) underrun_d = 1'b1;
      // A read and a write never hit the same bank: the write bank is never FULL
      if (rd_fire_c) begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (rd_last_c) begin
          bank_d[rd_sel_q] = BANK_EMPTY;
          rd_addr_d        = '0;
          rd_sel_d         = ~rd_sel_q;
          rd_total_d       = rd_total_next_c;
          if (rd_total_next_c == frame_words_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_words_q <= '0;
      wr_total_q    <= '0;
      rd_total_q    <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      bank_q[0]     <= BANK_EMPTY;
      bank_q[1]     <= BANK_EMPTY;
      cnt_q[0]      <= '0;
      cnt_q[1]      <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_words_q <= frame_words_d;
      wr_total_q    <= wr_total_d;
      rd_total_q    <= rd_total_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      cnt_q[0]      <= cnt_d[0];
      cnt_q[1]      <= cnt_d[1];
      valid_q       <= valid_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

  pingpong_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire_c),
    .waddr ({wr_sel_q, wr_addr_q}),
    .wdata (pp.wr_data_in),
    .re    (rd_fire_c),
    .raddr ({rd_sel_q, rd_addr_q}),
    .rdata (ram_rdata)
  );

  // RAM output is registered; gate it so idle and underrun cycles present zero
  assign pp.pingpong_data_out       = valid_q ? ram_rdata : '0;
  assign pp.pingpong_data_valid_out = valid_q;
  assign pp.pingpong_ready_out      = run_c && rd_full_c;
  assign pp.wr_ready_out            = wr_ready_c;
  assign busy_out                   = run_c;
  assign frame_done_out             = done_q;
  assign underrun_out               = underrun_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Randomized and directed bench for pingpong_ctrl against a queue-level model of the two banks.
module tb_pingpong_ctrl;

  localparam int DEPTH = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [23:0] frame_words_in;
  logic        busy_out, frame_done_out, underrun_out;

  pingpong_if #(.DATA_W(24)) pp_if ();

  pingpong_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .frame_words_in (frame_words_in),
    .pp             (pp_if),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .underrun_out   (underrun_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_done = 0;

  // Model: each bank is a word array with a fill level and a read pointer
  bit          started = 1'b0;
  bit          m_run;
  int unsigned m_fw, m_wrote, m_read;
  bit          m_full [2];
  int          m_fill [2];
  int          m_rp [2];
  logic [23:0] m_mem [2][DEPTH];
  bit          m_wsel, m_rsel;
  bit          e_valid, e_done, e_under, e_zero;
  logic [23:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit acc, rd, und, ws, rs;
    if (rst) begin
      started = 1'b1;
      m_run = 0; m_fw = 0; m_wrote = 0; m_read = 0;
      m_full = '{0, 0}; m_fill = '{0, 0}; m_rp = '{0, 0};
      m_wsel = 0; m_rsel = 0;
      e_valid = 0; e_done = 0; e_under = 0; e_zero = 1; e_data = '0;
    end else begin
      e_valid = 0; e_done = 0; e_zero = 0;
      if (!m_run) begin
        if (start_in && frame_words_in != 0) begin
          m_run = 1; m_fw = frame_words_in; m_wrote = 0; m_read = 0;
          m_full = '{0, 0}; m_fill = '{0, 0}; m_rp = '{0, 0};
          m_wsel = 0; m_rsel = 0; e_under = 0;
        end
      end else begin
        ws  = m_wsel;
        rs  = m_rsel;
        acc = pp_if.wr_valid_in && !m_full[ws] && (m_wrote < m_fw);
        rd  = pp_if.read_pingpong_in && m_full[rs];
        und = pp_if.read_pingpong_in && !m_full[rs];
        if (acc) begin
          m_mem[ws][m_fill[ws]] = pp_if.wr_data_in;
          m_fill[ws]++;
          m_wrote++;
          if (m_fill[ws] == DEPTH || m_wrote == m_fw) begin
            m_full[ws] = 1;
            m_wsel = !ws;
          end
        end
        if (rd) begin
          e_data  = m_mem[rs][m_rp[rs]];
          e_valid = 1;
          m_rp[rs]++;
          m_read++;
          if (m_rp[rs] == m_fill[rs]) begin
            m_full[rs] = 0; m_fill[rs] = 0; m_rp[rs] = 0;
            m_rsel = !rs;
            if (m_read == m_fw) begin
              m_run = 0;
              e_done = 1;
            end
          end
        end
        if (und) begin
          e_under = 1;
          e_zero = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy_out, m_run);
      chk("wr_ready", pp_if.wr_ready_out, m_run && !m_full[m_wsel] && (m_wrote < m_fw));
      chk("pp_ready", pp_if.pingpong_ready_out, m_run && m_full[m_rsel]);
      chk("data_valid", pp_if.pingpong_data_valid_out, e_valid);
      chk("frame_done", frame_done_out, e_done);
      chk("underrun", underrun_out, e_under);
      if (e_valid) chk("data", pp_if.pingpong_data_out, e_data);
      else if (e_zero) chk("data_zero", pp_if.pingpong_data_out, 0);
      if (pp_if.pingpong_data_valid_out) n_valid++;
      if (frame_done_out) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input int wp, input int rp, input bit polite);
    pp_if.wr_valid_in = ($urandom_range(0, 99) < wp);
    pp_if.wr_data_in  = 24'($urandom);
    pp_if.read_pingpong_in = ($urandom_range(0, 99) < rp) && (!polite || pp_if.pingpong_ready_out);
  endtask

  task automatic idle_inputs();
    pp_if.wr_valid_in = 0;
    pp_if.read_pingpong_in = 0;
    start_in = 0;
  endtask

  task automatic finish_frame(input int wp, input int rp, input bit polite);
    for (int c = 0; c < 20000 && m_run; c++) begin
      drive_rand(wp, rp, polite);
      tick();
    end
    idle_inputs();
    tick();
    if (m_run) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic begin_frame(input int fw);
    n_valid = 0; n_done = 0;
    idle_inputs();
    start_in = 1; frame_words_in = 24'(fw);
    tick();
    start_in = 0;
  endtask

  task automatic run_frame(input int fw, input int wp, input int rp, input bit polite);
    begin_frame(fw);
    finish_frame(wp, rp, polite);
    chk("n_valid", n_valid, fw);
    chk("n_done", n_done, 1);
  endtask

  task automatic fill_both();
    pp_if.wr_valid_in = 1; pp_if.read_pingpong_in = 0;
    for (int c = 0; c < 300 && !(m_full[0] && m_full[1]); c++) begin
      pp_if.wr_data_in = 24'($urandom);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; frame_words_in = 0;
    pp_if.wr_data_in = 0;
    idle_inputs();
    repeat (3) tick();
    chk("rst_busy", busy_out, 0);
    chk("rst_pp_ready", pp_if.pingpong_ready_out, 0);
    chk("rst_underrun", underrun_out, 0);
    rst = 0;
    tick();

    // Continuous source, polite sender
    run_frame(160, 100, 100, 1);
    chk("underrun_160", underrun_out, 0);
    // Short last bank of 20 words
    run_frame(100, 100, 100, 1);

    // Both banks full, then drain bank 0 and watch the write bubble
    begin_frame(240);
    fill_both();
    pp_if.wr_valid_in = 1;
    tick();
    chk("wr_ready_both_full", pp_if.wr_ready_out, 0);
    pp_if.read_pingpong_in = 1;
    repeat (79) tick();
    chk("wr_ready_on_read80", pp_if.wr_ready_out, 0);
    tick();
    pp_if.read_pingpong_in = 0;
    chk("wr_ready_after_read80", pp_if.wr_ready_out, 1);
    finish_frame(100, 100, 1);
    chk("n_valid_240", n_valid, 240);

    // Source stalls while the sender keeps strobing
    begin_frame(200);
    fill_both();
    pp_if.wr_valid_in = 0;
    pp_if.read_pingpong_in = 1;
    repeat (170) tick();
    chk("underrun_set", underrun_out, 1);
    chk("n_valid_drained", n_valid, 160);
    finish_frame(100, 100, 1);
    chk("n_valid_200", n_valid, 200);

    // Zero-length start ignored; start during RUN ignored
    idle_inputs();
    start_in = 1; frame_words_in = 0;
    tick();
    start_in = 0;
    tick();
    chk("busy_zero_frame", busy_out, 0);
    begin_frame(80);
    for (int c = 0; c < 10; c++) begin
      drive_rand(100, 0, 1);
      start_in = (c == 4);
      frame_words_in = 24'd7;
      tick();
    end
    start_in = 0;
    finish_frame(100, 100, 1);
    chk("n_valid_80", n_valid, 80);

    // Reset mid-transfer after 50 accepted words
    begin_frame(160);
    pp_if.wr_valid_in = 1;
    for (int c = 0; c < 200 && m_wrote < 50; c++) tick();
    pp_if.wr_valid_in = 0;
    rst = 1;
    tick();
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_wr_ready", pp_if.wr_ready_out, 0);
    chk("mid_rst_pp_ready", pp_if.pingpong_ready_out, 0);
    chk("mid_rst_valid", pp_if.pingpong_data_valid_out, 0);
    chk("mid_rst_done", frame_done_out, 0);
    chk("mid_rst_underrun", underrun_out, 0);
    chk("mid_rst_data", pp_if.pingpong_data_out, 0);
    rst = 0;
    tick();
    run_frame(80, 100, 100, 1);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(1, 300)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pingpong_ctrl.md
Name: pingpong_ctrl

Overview:
- Two-bank line buffer controller between the frame-data source (DDR reader / stream FIFO) and the WPS pixel sender.
- Sequences bank fills from the source stream and serves word reads to the sender, which reads at most one bank per DE line.
- Asserts pingpong_ready_out once a bank is full, and reports frame completion and underrun.

Parameters:
- DATA_W, 24, pixel word width.
- DEPTH, 80, words per bank (one DE line burst).
- ADDR_W, 7, bank address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  one-cycle pulse that begins a frame transfer.
- frame_words_in  in  24  words in this frame; sampled on start_in.
- wr_data_in  in  DATA_W  source word.
- wr_valid_in  in  1  source word valid.
- wr_ready_out  out  1  controller accepts the source word.
- read_pingpong_in  in  1  read strobe from the sender.
- pingpong_data_out  out  DATA_W  read word.
- pingpong_data_valid_out  out  1  pingpong_data_out valid.
- pingpong_ready_out  out  1  the bank at rd_sel is FULL.
- busy_out  out  1  a frame transfer is in progress.
- frame_done_out  out  1  one-cycle pulse after the last frame word is read.
- underrun_out  out  1  sticky: a read arrived with no FULL bank; cleared by start_in or rst.

Behaviour:
- Reset: all outputs are 0. Both banks EMPTY; wr_sel = rd_sel = 0. wr_addr, rd_addr, wr_total and rd_total are 0.
- Top FSM:
  - IDLE -> RUN on start_in when frame_words_in != 0. Latch frame_words_in into frame_words_reg; clear the counters and underrun_out.
  - start_in with frame_words_in == 0 is ignored.
  - start_in while in RUN is ignored.
  - RUN -> IDLE when rd_total reaches frame_words_reg. frame_done_out pulses for 1 cycle in that transition cycle.
  - busy_out = (state == RUN).
- Per-bank state: EMPTY, FILLING, FULL. Each bank also has a registered fill count, cnt[b], width ADDR_W+1.
- Write side:
  - wr_ready_out = RUN & bank[wr_sel] != FULL & wr_total < frame_words_reg. It is combinational from registers only, never from wr_valid_in.
  - On an accepted word: write RAM[wr_sel][wr_addr], wr_addr++, wr_total++, and the bank goes FILLING.
  - The bank closes when wr_addr == DEPTH-1 or wr_total == frame_words_reg-1 at acceptance. On close: bank -> FULL, cnt = wr_addr+1, wr_addr = 0, wr_sel toggles.
  - A short last bank is legal.
- Read side:
  - If read_pingpong_in and bank[rd_sel] == FULL: read RAM[rd_sel][rd_addr] and rd_addr++.
  - pingpong_data_out and pingpong_data_valid_out are registered, so data appears exactly 1 cycle after the strobe.
  - On the read with rd_addr == cnt-1: bank -> EMPTY, rd_addr = 0, rd_sel toggles, rd_total += cnt.
  - If read_pingpong_in and bank[rd_sel] != FULL: no RAM access, pingpong_data_valid_out = 0 and pingpong_data_out = 0 next cycle, underrun_out set.
  - Reads are ignored (no underrun flagged) in IDLE.
- pingpong_ready_out = RUN & bank[rd_sel] == FULL. It is registered-state derived and deasserts in the cycle after the bank's last read.
- Simultaneous events:
  - Write-close of one bank and read-empty of the other bank in the same cycle: both take effect.
  - The read side frees bank X in the cycle the write side targets X: wr_ready_out stays 0 that cycle, and the write is accepted the next cycle. This 1-cycle bubble is required, so no same-address read/write collision occurs.
- Counters are 24-bit and do not wrap; frame_words_reg max is 2^24-1.
- rst mid-transfer: immediate return to the reset state on the next edge. In-flight RAM contents are don't-care; no output pulses.

Decomposition:
- Package pingpong_pkg:
  - bank-state encoding (EMPTY=0, FILLING=1, FULL=2);
  - top FSM encoding (IDLE=0, RUN=1);
  - DEPTH and ADDR_W defaults shared with the sender's read-brake constant.
- Sub-module pingpong_bank_ram: simple dual-port RAM, depth 2*DEPTH, addressed {sel, addr}, registered read, one write and one read port.

Test Plan:
- start_in with frame_words_in=160, continuous source, sender reads 80 per line:
  - pingpong_ready_out rises 1 cycle after word 80 is accepted.
  - 160 valid words arrive in order.
  - frame_done_out pulses once.
  - underrun_out stays 0.
- frame_words_in=100: second bank closes with cnt=20. The 20th read empties it, and frame_done_out fires after read 100.
- Source stalls (wr_valid_in low) while both banks drain, sender keeps strobing: underrun_out sets, pingpong_data_valid_out stays 0 on those reads.
- Both banks FULL: wr_ready_out = 0.
  - The cycle read 80 empties bank 0: wr_ready_out is still 0.
  - The next cycle: wr_ready_out = 1 and the write lands in bank 0.
- frame_words_in=0 with start_in: busy_out stays 0. A later start_in during RUN does not change frame_words_reg.
- rst asserted after 50 words accepted: the next cycle shows all outputs 0. A new start_in with frame_words_in=80 then completes normally.
